// File: rtl/decoder_pkg.sv
// decoder_pkg
// Shared definitions for the registered N-to-2**N decoder.
//   mode_t  : output pattern select (one-hot, thermometer, inverted one-hot, scan)
//   state_t : output-register FSM state (EMPTY, FULL, SCAN)
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT   = 2'b00,
    MODE_THERMO   = 2'b01,
    MODE_ONEHOT_N = 2'b10,
    MODE_SCAN     = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,  // no word held
    ST_FULL  = 2'b01,  // holding the final word of a transaction
    ST_SCAN  = 2'b10   // holding a non-final scan word
  } state_t;

endpackage

// File: rtl/decoder_pattern.sv
// decoder_pattern
// Combinational map from (index, mode) to a 2**N-bit word.
// Ports:
//   idx  in  N      index to decode
//   mode in  2      pattern select; MODE_SCAN yields the one-hot word
//                   (the scan start word is one-hot of the start index)
//   word out 2**N   decoded word
module decoder_pattern
  import decoder_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]      idx,
  input  mode_t             mode,
  output logic [(1<<N)-1:0] word
);

  localparam int W = 1 << N;
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] onehot;
  logic [W-1:0] thermo;

  // Thermometer is (1 << (k+1)) - 1; for k = W-1 the shift drops out to 0
  // and the subtraction wraps to all ones, which is the wanted value.
  assign onehot = ONE << idx;
  assign thermo = (onehot << 1) - ONE;

  always_comb begin
    word = onehot;
    unique case (mode)
      MODE_ONEHOT:   word = onehot;
      MODE_THERMO:   word = thermo;
      MODE_ONEHOT_N: word = ~onehot;
      MODE_SCAN:     word = onehot;
      default:       word = onehot;
    endcase
  end

endmodule

// File: rtl/decoder_seq_nx2pn.sv
// decoder_seq_nx2pn
// Registered, valid/ready flow-controlled N-to-2**N decoder.
// Optional feature macro: DECODER_SCAN_EN (MODE=11 sweeps one-hot upward
// from the start index; without it MODE=11 decodes as one-hot).
//
// Handshake: a word moves on an interface only in a cycle where its
// valid and ready are both 1. IN side accepts IN/MODE on IN_VALID&&IN_READY;
// OUT side hands over OUT/OUT_LAST on OUT_VALID&&OUT_READY. OUT_VALID, once
// high, stays high with OUT/OUT_LAST frozen until taken.
//
// Ports:
//   CLK       in   1     rising-edge clock
//   RST       in   1     synchronous active-high reset
//   IN        in   N     index to decode
//   MODE      in   2     pattern select (sampled with IN)
//   IN_VALID  in   1     IN/MODE valid
//   IN_READY  out  1     input accepted this cycle if IN_VALID
//   OUT       out  2**N  decoded word (registered)
//   OUT_VALID out  1     OUT holds a word
//   OUT_LAST  out  1     OUT is the final word of its transaction
//   OUT_READY in   1     consumer takes OUT this cycle
//   fsm_state out  2     current FSM state, for observation
module decoder_seq_nx2pn
  import decoder_pkg::*;
#(
  parameter int N = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N-1:0]      IN,
  input  logic [1:0]        MODE,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [(1<<N)-1:0] OUT,
  output logic              OUT_VALID,
  output logic              OUT_LAST,
  input  logic              OUT_READY,
  output state_t            fsm_state
);

  localparam int W = 1 << N;
  localparam logic [N-1:0] MAX_IDX = '1;

  state_t       state, state_n;
  logic [W-1:0] out_q, out_n;
  logic         last_q, last_n;
  logic [N-1:0] pat_idx;
  mode_t        pat_mode;
  logic [W-1:0] pat_word;
  logic         in_rdy;

`ifdef DECODER_SCAN_EN
  logic [N-1:0] cnt, cnt_n;
  logic [N-1:0] cnt_inc;
  assign cnt_inc = cnt + 1'b1;
`endif

  // One pattern generator serves both the input path and the scan advance;
  // while scanning the input is not accepted, so the two never collide.
  always_comb begin
    pat_idx  = IN;
    pat_mode = mode_t'(MODE);
`ifdef DECODER_SCAN_EN
    if (state == ST_SCAN) begin
      pat_idx  = cnt_inc;
      pat_mode = MODE_ONEHOT;
    end
`endif
  end

  decoder_pattern #(.N(N)) u_pattern (
    .idx  (pat_idx),
    .mode (pat_mode),
    .word (pat_word)
  );

  always_comb begin
    state_n = state;
    out_n   = out_q;
    last_n  = last_q;
    in_rdy  = 1'b0;
`ifdef DECODER_SCAN_EN
    cnt_n   = cnt;
`endif

    unique case (state)
      ST_EMPTY: in_rdy = 1'b1;
      ST_FULL:  in_rdy = OUT_READY;
      ST_SCAN: begin
`ifdef DECODER_SCAN_EN
        if (OUT_READY) begin
          out_n = pat_word;
          cnt_n = cnt_inc;
          if (cnt_inc == MAX_IDX) begin
            state_n = ST_FULL;
            last_n  = 1'b1;
          end
        end
`endif
      end
      default: ;
    endcase

    if (in_rdy && IN_VALID) begin
      out_n   = pat_word;
      last_n  = 1'b1;
      state_n = ST_FULL;
`ifdef DECODER_SCAN_EN
      cnt_n   = IN;
      // Starting at the top index is a single final word, not a scan.
      if (mode_t'(MODE) == MODE_SCAN && IN != MAX_IDX) begin
        state_n = ST_SCAN;
        last_n  = 1'b0;
      end
`endif
    end else if (state == ST_FULL && OUT_READY) begin
      state_n = ST_EMPTY;
      last_n  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_EMPTY;
      out_q  <= '0;
      last_q <= 1'b0;
`ifdef DECODER_SCAN_EN
      cnt    <= '0;
`endif
    end else begin
      state  <= state_n;
      out_q  <= out_n;
      last_q <= last_n;
`ifdef DECODER_SCAN_EN
      cnt    <= cnt_n;
`endif
    end
  end

  assign IN_READY  = in_rdy;
  assign OUT       = out_q;
  assign OUT_VALID = (state != ST_EMPTY);
  assign OUT_LAST  = last_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_decoder_seq_nx2pn.sv
// tb_decoder_seq_nx2pn
// Directed bench for decoder_seq_nx2pn with N=3: a vector table of
// back-to-back decodes plus hand-written backpressure, scan and reset
// sequences. Scan sequences follow DECODER_SCAN_EN.
module tb_decoder_seq_nx2pn;
  import decoder_pkg::*;

  localparam int N = 3;
  localparam int W = 1 << N;

  logic         clk;
  logic         rst;
  logic [N-1:0] in_idx;
  logic [1:0]   mode;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_word;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;
  state_t       fsm_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] idx;
    logic [1:0]   mode;
    logic [W-1:0] exp_out;
  } vec_t;

  vec_t vecs[10];

  decoder_seq_nx2pn #(.N(N)) dut (
    .CLK       (clk),
    .RST       (rst),
    .IN        (in_idx),
    .MODE      (mode),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .OUT       (out_word),
    .OUT_VALID (out_valid),
    .OUT_LAST  (out_last),
    .OUT_READY (out_ready),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] idx, input logic [1:0] m, input logic rdy);
    in_valid  = v;
    in_idx    = idx;
    mode      = m;
    out_ready = rdy;
    #1;
  endtask

  task automatic check_word(input string name, input logic [W-1:0] w, input logic last);
    check({name, "_out"}, 32'(out_word), 32'(w));
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_last"}, 32'(out_last), 32'(last));
  endtask

  task automatic check_empty(input string name);
    check({name, "_out"}, 32'(out_word), 32'h0);
    check({name, "_valid"}, 32'(out_valid), 32'd0);
    check({name, "_last"}, 32'(out_last), 32'd0);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 2'b00, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{3'd5, 2'b00, 8'h20};
    vecs[1] = '{3'd5, 2'b01, 8'h3F};
    vecs[2] = '{3'd5, 2'b10, 8'hDF};
    vecs[3] = '{3'd0, 2'b00, 8'h01};
    vecs[4] = '{3'd0, 2'b01, 8'h01};
    vecs[5] = '{3'd0, 2'b10, 8'hFE};
    vecs[6] = '{3'd7, 2'b01, 8'hFF};
    vecs[7] = '{3'd7, 2'b00, 8'h80};
    vecs[8] = '{3'd3, 2'b01, 8'h0F};
    vecs[9] = '{3'd2, 2'b10, 8'hFB};

    rst = 1'b1;
    in_valid = 1'b0; in_idx = '0; mode = 2'b00; out_ready = 1'b0;

    // reset then idle
    do_reset();
    tick();
    check_empty("reset");
    check("reset_state", 32'(fsm_state), 32'(ST_EMPTY));

    // back-to-back table, one word per cycle
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].idx, vecs[i].mode, 1'b1);
      check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'd1);
      tick();
      check_word($sformatf("tbl%0d", i), vecs[i].exp_out, 1'b1);
    end
    drive(1'b0, '0, 2'b00, 1'b1);
    tick();
    check("tbl_drain_valid", 32'(out_valid), 32'd0);

    // backpressure: word held while IN changes
    drive(1'b1, 3'd5, 2'b00, 1'b0);
    tick();
    check_word("bp_load", 8'h20, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 2)), 1'b0);
      check($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
      tick();
      check_word($sformatf("bp%0d", i), 8'h20, 1'b1);
    end
    drive(1'b1, 3'd2, 2'b00, 1'b1);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    check_word("bp_next", 8'h04, 1'b1);
    drive(1'b0, '0, 2'b00, 1'b1);
    tick();
    check("bp_drain_valid", 32'(out_valid), 32'd0);

`ifdef DECODER_SCAN_EN
    // scan from 5 with a pending input that must wait for the last word
    drive(1'b1, 3'd5, 2'b11, 1'b1);
    tick();
    drive(1'b1, 3'd1, 2'b00, 1'b1);
    check_word("scan5_w0", 8'h20, 1'b0);
    check("scan5_w0_in_ready", 32'(in_ready), 32'd0);
    tick();
    check_word("scan5_w1", 8'h40, 1'b0);
    check("scan5_w1_in_ready", 32'(in_ready), 32'd0);
    tick();
    check_word("scan5_w2", 8'h80, 1'b1);
    check("scan5_w2_in_ready", 32'(in_ready), 32'd1);
    tick();
    check_word("scan5_after", 8'h02, 1'b1);
    drive(1'b0, '0, 2'b00, 1'b1);
    tick();
    check("scan5_drain_valid", 32'(out_valid), 32'd0);

    // scan from the top index is a single final word
    drive(1'b1, 3'd7, 2'b11, 1'b1);
    tick();
    drive(1'b0, '0, 2'b00, 1'b1);
    check_word("scan7", 8'h80, 1'b1);
    tick();
    check("scan7_drain_valid", 32'(out_valid), 32'd0);

    // scan with a stall mid-sweep
    drive(1'b1, 3'd5, 2'b11, 1'b0);
    tick();
    drive(1'b0, '0, 2'b00, 1'b0);
    tick();
    check_word("scanbp_hold", 8'h20, 1'b0);
    drive(1'b0, '0, 2'b00, 1'b1);
    tick();
    check_word("scanbp_w1", 8'h40, 1'b0);
    drive(1'b0, '0, 2'b00, 1'b0);
    tick();
    check_word("scanbp_w1_hold", 8'h40, 1'b0);
    drive(1'b0, '0, 2'b00, 1'b1);
    tick();
    check_word("scanbp_w2", 8'h80, 1'b1);
    tick();
    check("scanbp_drain_valid", 32'(out_valid), 32'd0);

    // reset mid-scan aborts it
    drive(1'b1, 3'd0, 2'b11, 1'b1);
    tick();
    drive(1'b0, '0, 2'b00, 1'b1);
    check_word("scan0_w0", 8'h01, 1'b0);
    tick();
    check_word("scan0_w1", 8'h02, 1'b0);
    tick();
    check_word("scan0_w2", 8'h04, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_empty("scan0_rst");
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("scan0_post%0d_valid", i), 32'(out_valid), 32'd0);
    end
`else
    // MODE=11 decodes as plain one-hot
    drive(1'b1, 3'd7, 2'b11, 1'b1);
    tick();
    drive(1'b1, 3'd2, 2'b11, 1'b1);
    check_word("m3_idx7", 8'h80, 1'b1);
    check("m3_idx7_in_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, '0, 2'b00, 1'b1);
    check_word("m3_idx2", 8'h04, 1'b1);
    tick();
    check("m3_drain_valid", 32'(out_valid), 32'd0);
    check("m3_drain_last", 32'(out_last), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
